// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding and
// the clocks-per-bit divisor derived from the clock and baud parameters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  // Integer division of the two rates; fractional remainders are dropped.
  function automatic int clks_per_bit(input real clk_freq, input real baud_rate);
    return $rtoi(clk_freq) / $rtoi(baud_rate);
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// parameterised reset value so an idle-high line stays high through reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_sreset,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_sreset) r_sync <= {2{RST_VAL}};
    else          r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1-style, DATA_BITS configurable) with an AXI-Stream output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit target.
// Handshake: a word transfers on any cycle where m_axis_tvalid && m_axis_tready;
// tvalid is never dropped and tdata never changes until that transfer happens.
module uart_rx
  import uart_pkg::*;
#(
  parameter real CLK_FREQ  = 100e6,
  parameter real BAUD_RATE = 9600,
  parameter int  DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 sreset,
  input  logic                 serial_data,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 framing_err,
  output logic                 overrun,
  output uart_rx_state_t       o_dbg_state
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CTR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CTR_W-1:0] FULL_LAST = CTR_W'(CLKS_PER_BIT - 1);
  localparam logic [CTR_W-1:0] HALF_LAST = CTR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_rx_state_t       r_state, w_state_nx;
  logic [CTR_W-1:0]     r_baud_ctr, w_baud_ctr_nx;
  logic [BIT_W-1:0]     r_bit_ctr, w_bit_ctr_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx;
  logic                 r_tvalid, w_tvalid_nx;
  logic [DATA_BITS-1:0] r_tdata, w_tdata_nx;
  logic                 r_ferr, r_ovr, w_ovr_nx;
  logic                 w_tick, w_sample_en, w_bit;
  logic                 w_frame_ok, w_frame_bad;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk    (clk),
    .i_sreset (sreset),
    .i_d      (serial_data),
    .o_q      (w_rx_s)
  );

  // The start bit is checked at its midpoint; later bits at a full period.
  assign w_tick = (r_state != IDLE) &&
                  (r_baud_ctr == ((r_state == START) ? HALF_LAST : FULL_LAST));

`ifdef UART_RX_MAJORITY_EN
  // Vote over target-1, target, target+1; the decision lands one cycle after the target.
  logic [1:0] r_hist;
  logic       r_tick_d;

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_hist   <= 2'b11;
      r_tick_d <= 1'b0;
    end else begin
      r_hist   <= {r_hist[0], w_rx_s};
      r_tick_d <= w_tick;
    end
  end

  assign w_sample_en = r_tick_d;
  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
  assign w_sample_en = w_tick;
  assign w_bit       = w_rx_s;
`endif

  always_comb begin
    w_state_nx    = r_state;
    w_baud_ctr_nx = (r_baud_ctr == FULL_LAST) ? '0 : r_baud_ctr + 1'b1;
    w_bit_ctr_nx  = r_bit_ctr;
    w_shift_nx    = r_shift;
    w_frame_ok    = 1'b0;
    w_frame_bad   = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_ctr_nx = '0;
        if (!w_rx_s) w_state_nx = START;
      end
      START: begin
        if (w_sample_en) begin
          if (w_bit) begin
            w_state_nx = IDLE;
          end else begin
            w_state_nx    = DATA;
            w_baud_ctr_nx = '0;
            w_bit_ctr_nx  = '0;
          end
        end
      end
      DATA: begin
        if (w_sample_en) begin
          w_shift_nx   = {w_bit, r_shift[DATA_BITS-1:1]};
          w_bit_ctr_nx = r_bit_ctr + 1'b1;
          if (r_bit_ctr == BIT_LAST) w_state_nx = STOP;
        end
      end
      STOP: begin
        if (w_sample_en) begin
          w_state_nx  = IDLE;
          w_frame_ok  = w_bit;
          w_frame_bad = !w_bit;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // A completed word is only loaded when the output slot is free or draining this cycle.
  always_comb begin
    w_tvalid_nx = r_tvalid;
    w_tdata_nx  = r_tdata;
    w_ovr_nx    = 1'b0;
    if (r_tvalid && m_axis_tready) w_tvalid_nx = 1'b0;
    if (w_frame_ok) begin
      if (!r_tvalid || m_axis_tready) begin
        w_tvalid_nx = 1'b1;
        w_tdata_nx  = r_shift;
      end else begin
        w_ovr_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state    <= IDLE;
      r_baud_ctr <= '0;
      r_bit_ctr  <= '0;
      r_shift    <= '0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_baud_ctr <= w_baud_ctr_nx;
      r_bit_ctr  <= w_bit_ctr_nx;
      r_shift    <= w_shift_nx;
      r_tvalid   <= w_tvalid_nx;
      r_tdata    <= w_tdata_nx;
      r_ferr     <= w_frame_bad;
      r_ovr      <= w_ovr_nx;
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign framing_err   = r_ferr;
  assign overrun       = r_ovr;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 100 clocks per bit: vector table,
// hand-written corner sequences, and randomized frames against a queue model.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB   = 100;
  localparam int NBITS = 8;
  localparam int FRAME = (NBITS + 2) * CPB;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GLITCH_EXP = 8'h00;
  localparam int         LAT_NOM    = 953;
`else
  localparam logic [7:0] GLITCH_EXP = 8'h08;
  localparam int         LAT_NOM    = 952;
`endif

  logic           clk = 1'b0;
  logic           sreset;
  logic           serial_data;
  logic           m_axis_tready;
  logic           m_axis_tvalid;
  logic [7:0]     m_axis_tdata;
  logic           framing_err;
  logic           overrun;
  uart_rx_state_t dbg_state;

  uart_rx #(
    .CLK_FREQ  (100e6),
    .BAUD_RATE (1e6),
    .DATA_BITS (NBITS)
  ) dut (
    .clk           (clk),
    .sreset        (sreset),
    .serial_data   (serial_data),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .framing_err   (framing_err),
    .overrun       (overrun),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         n_words = 0, n_ferr = 0, n_ovr = 0;
  int         rise_cyc = 0;
  logic       prev_hold = 1'b0, prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!sreset) begin
      if (m_axis_tvalid && m_axis_tready) begin
        n_words++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h with nothing expected", m_axis_tdata);
        end else begin
          check("tdata", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
        end
      end
      if (prev_hold && m_axis_tvalid) check("tdata_stable", 32'(m_axis_tdata), 32'(prev_data));
      if (framing_err || overrun) check("ferr_ovr_exclusive", 32'(framing_err && overrun), 32'd0);
      if (framing_err) n_ferr++;
      if (overrun) n_ovr++;
      if (m_axis_tvalid && !prev_valid) rise_cyc = cyc;
    end
    prev_hold  = m_axis_tvalid && !m_axis_tready;
    prev_valid = m_axis_tvalid;
    prev_data  = m_axis_tdata;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    n_words = 0;
    n_ferr  = 0;
    n_ovr   = 0;
  endtask

  task automatic do_reset();
    sreset      = 1'b1;
    serial_data = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    sreset = 1'b0;
  endtask

  // Drives the first n_cycles of a frame; glitch_idx inverts one line cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_idx,
                            input int n_cycles);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < n_cycles; i++) begin
      @(posedge clk);
      #1;
      serial_data = bits[i / CPB] ^ (i == glitch_idx);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      serial_data = 1'b1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         glitch;
    logic [7:0] exp_data;
    int         exp_words;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    int         start_cyc;
    int         lat;
    logic [7:0] d;
    logic       stop, t, held;
    int         exp_words, exp_ferr, exp_ovr;

    m_axis_tready = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_ferr", 32'(framing_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    vecs[0] = '{8'hA5, 1'b1, -1, 8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, -1, 8'h00, 0, 1};
    vecs[2] = '{8'h00, 1'b1, 4 * CPB + CPB / 2, GLITCH_EXP, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, -1, 8'hFF, 1, 0};
    vecs[4] = '{8'h01, 1'b1, -1, 8'h01, 1, 0};
    vecs[5] = '{8'h80, 1'b1, -1, 8'h80, 1, 0};

    m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clear_counts();
      if (vecs[i].exp_words != 0) exp_q.push_back(vecs[i].exp_data);
      start_cyc = cyc + 1;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].glitch, FRAME);
      idle(CPB + 50);
      wait_drain($sformatf("vec%0d_drain", i));
      check($sformatf("vec%0d_words", i), 32'(n_words), 32'(vecs[i].exp_words));
      check($sformatf("vec%0d_ferr", i), 32'(n_ferr), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_ovr", i), 32'(n_ovr), 32'd0);
      check($sformatf("vec%0d_tvalid_low", i), 32'(m_axis_tvalid), 32'd0);
      check($sformatf("vec%0d_idle", i), 32'(dbg_state), 32'(IDLE));
      if (i == 0) begin
        lat = rise_cyc - start_cyc;
        check("latency_window", 32'(lat >= LAT_NOM - 3 && lat <= LAT_NOM + 3), 32'd1);
      end
    end

    // Short low pulse: false start, back in IDLE by cycle 55.
    clear_counts();
    for (int i = 0; i < 56; i++) begin
      @(posedge clk);
      #1;
      serial_data = (i >= 30);
      if (i == 20) check("pulse_in_start", 32'(dbg_state), 32'(START));
    end
    @(negedge clk);
    check("pulse_idle_by_55", 32'(dbg_state), 32'(IDLE));
    idle(CPB);
    check("pulse_words", 32'(n_words), 32'd0);
    check("pulse_ferr", 32'(n_ferr), 32'd0);
    check("pulse_ovr", 32'(n_ovr), 32'd0);

    // Back-to-back frames with tready low: second word overruns.
    clear_counts();
    m_axis_tready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, FRAME);
    @(negedge clk);
    check("ovr_first_held", 32'(m_axis_tvalid), 32'd1);
    check("ovr_none_yet", 32'(n_ovr), 32'd0);
    send_frame(8'h22, 1'b1, -1, FRAME);
    idle(50);
    @(negedge clk);
    check("ovr_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("ovr_tdata_held", 32'(m_axis_tdata), 32'h11);
    check("ovr_pulse_once", 32'(n_ovr), 32'd1);
    check("ovr_no_handshake", 32'(n_words), 32'd0);
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    idle(20);
    wait_drain("ovr_drain");
    check("ovr_words", 32'(n_words), 32'd1);
    check("ovr_tvalid_low", 32'(m_axis_tvalid), 32'd0);

    // Reset pulse in the middle of data bit 4, then a clean frame.
    clear_counts();
    send_frame(8'h77, 1'b1, -1, 5 * CPB + CPB / 2);
    @(posedge clk);
    #1;
    sreset      = 1'b1;
    serial_data = 1'b1;
    @(posedge clk);
    #1;
    sreset = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    idle(2 * CPB);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, FRAME);
    idle(CPB + 50);
    wait_drain("midrst_drain");
    check("midrst_words", 32'(n_words), 32'd1);
    check("midrst_ferr", 32'(n_ferr), 32'd0);
    check("midrst_ovr", 32'(n_ovr), 32'd0);

    // Random frames against a word-level model of the single output slot.
    clear_counts();
    held      = 1'b0;
    exp_words = 0;
    exp_ferr  = 0;
    exp_ovr   = 0;
    for (int k = 0; k < 20; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      t    = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      m_axis_tready = t;
      if (t) held = 1'b0;
      if (!stop) begin
        exp_ferr++;
      end else if (held) begin
        exp_ovr++;
      end else begin
        exp_q.push_back(d);
        exp_words++;
        if (!t) held = 1'b1;
      end
      send_frame(d, stop, -1, FRAME);
      idle(CPB);
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    idle(10);
    wait_drain("rand_drain");
    check("rand_words", 32'(n_words), 32'(exp_words));
    check("rand_ferr", 32'(n_ferr), 32'(exp_ferr));
    check("rand_ovr", 32'(n_ovr), 32'(exp_ovr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
